// File: rtl/lapido_pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lapido_pipe_ctrl_pkg
// Shared definitions for the LAPI DOpaCA pipeline hazard/sequencing controller:
//   - REG_ADDR_W        : register-file address width
//   - CTRL_LATENCY_DEF  : default cycles from control issue to WB resolution
//   - PIPE_RUN / PIPE_CTRL_WAIT : controller state encodings
//   - trk_entry_t       : one destination-tracker entry {valid, dst}
// -----------------------------------------------------------------------------
package lapido_pipe_ctrl_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int CTRL_LATENCY_DEF = 3;

    localparam logic [0:0] PIPE_RUN       = 1'b0;
    localparam logic [0:0] PIPE_CTRL_WAIT = 1'b1;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
    } trk_entry_t;

endpackage

// File: rtl/lapido_dst_tracker.sv
// -----------------------------------------------------------------------------
// lapido_dst_tracker
// Three-entry shift chain (EX, MEM, WB) of destination registers in flight,
// with match comparators for the two ID source operands.
// Ports:
//   clk         in   pipeline clock, rising edge
//   rst         in   asynchronous active-low reset (clears entry valids)
//   push_vld_i  in   instruction leaving ID writes a non-zero register
//   push_dst_i  in   its destination register
//   rs_i, rt_i  in   ID source register fields
//   rs_hit_o    out  rs matches any valid entry
//   rt_hit_o    out  rt matches any valid entry
// -----------------------------------------------------------------------------
module lapido_dst_tracker
    import lapido_pipe_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_vld_i,
    input  logic [REG_ADDR_W-1:0] push_dst_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rt_i,
    output logic                  rs_hit_o,
    output logic                  rt_hit_o
);

    logic                  ex_vld_q,  mem_vld_q,  wb_vld_q;
    logic [REG_ADDR_W-1:0] ex_dst_q,  mem_dst_q,  wb_dst_q;

    // Valid bits are the only state that must be cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_vld_q  <= 1'b0;
            mem_vld_q <= 1'b0;
            wb_vld_q  <= 1'b0;
        end else begin
            ex_vld_q  <= push_vld_i;
            mem_vld_q <= ex_vld_q;
            wb_vld_q  <= mem_vld_q;
        end
    end

    always_ff @(posedge clk) begin
        ex_dst_q  <= push_dst_i;
        mem_dst_q <= ex_dst_q;
        wb_dst_q  <= mem_dst_q;
    end

    // WB is included because the register file does not forward a write to a
    // read in the same cycle.
    always_comb begin
        rs_hit_o = (ex_vld_q  && (ex_dst_q  == rs_i)) ||
                   (mem_vld_q && (mem_dst_q == rs_i)) ||
                   (wb_vld_q  && (wb_dst_q  == rs_i));
        rt_hit_o = (ex_vld_q  && (ex_dst_q  == rt_i)) ||
                   (mem_vld_q && (mem_dst_q == rt_i)) ||
                   (wb_vld_q  && (wb_dst_q  == rt_i));
    end

endmodule

// File: rtl/lapido_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// lapido_pipe_ctrl
// Hazard and sequencing controller for the 5-stage LAPI DOpaCA pipeline.
// Stalls ID on RAW hazards against EX/MEM/WB destinations, holds fetch while a
// control instruction travels to WB, and redirects/flushes on taken control.
// Ports:
//   clk, rst                  clock (rising) / async active-low reset
//   id_valid .. id_is_ctrl    decoded fields of the instruction in ID
//   wb_ctrl_resolved          strobe: control instruction is in WB
//   wb_redirect               taken (1) / not taken (0), qualified by strobe
//   pc_write_enable           PC load enable
//   pc_sel_target             PC loads WB target instead of PC+1
//   if_id_write_enable        IF/ID load enable
//   if_id_flush               IF/ID loads a NOP
//   id_ex_bubble              ID/EX loads a NOP
//   data_stall                data hazard active this cycle
//   ctrl_timeout              sticky: resolution strobe missed its window
//   stall_cycles              saturating count of bubble cycles
// -----------------------------------------------------------------------------
module lapido_pipe_ctrl
    import lapido_pipe_ctrl_pkg::*;
#(
    parameter int CTRL_LATENCY = CTRL_LATENCY_DEF,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_reg_write_enable,
    input  logic [REG_ADDR_W-1:0]  id_reg_dst,
    input  logic                   id_is_ctrl,
    input  logic                   wb_ctrl_resolved,
    input  logic                   wb_redirect,
    output logic                   pc_write_enable,
    output logic                   pc_sel_target,
    output logic                   if_id_write_enable,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   data_stall,
    output logic                   ctrl_timeout,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = (CTRL_LATENCY < 2) ? 1 : $clog2(CTRL_LATENCY + 1);

    logic [0:0]             state_q,   state_d;
    logic [WAIT_W-1:0]      wait_q,    wait_d;
    logic                   timeout_q, timeout_d;
    logic [STALL_CNT_W-1:0] stall_q,   stall_d;

    logic rs_hit, rt_hit, hazard;
    logic pc_we_c, pc_sel_c, ifid_we_c, flush_c, bubble_c, dstall_c;

    lapido_dst_tracker u_tracker (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (id_valid && id_reg_write_enable && !id_ex_bubble &&
                     (id_reg_dst != '0)),
        .push_dst_i (id_reg_dst),
        .rs_i       (id_rs),
        .rt_i       (id_rt),
        .rs_hit_o   (rs_hit),
        .rt_hit_o   (rt_hit)
    );

    // r0 is hard-wired zero, so reading it can never depend on a producer.
    assign hazard = id_valid &&
                    ((id_uses_rs && (id_rs != '0) && rs_hit) ||
                     (id_uses_rt && (id_rt != '0) && rt_hit));

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        pc_we_c   = 1'b0;
        pc_sel_c  = 1'b0;
        ifid_we_c = 1'b0;
        flush_c   = 1'b0;
        bubble_c  = 1'b0;
        dstall_c  = 1'b0;
        case (state_q)
            PIPE_RUN: begin
                // A stalled control instruction waits here until its operands
                // are ready; it only issues on a hazard-free cycle.
                if (hazard) begin
                    dstall_c = 1'b1;
                    bubble_c = 1'b1;
                end else begin
                    pc_we_c   = 1'b1;
                    ifid_we_c = 1'b1;
                    if (id_valid && id_is_ctrl) begin
                        state_d = PIPE_CTRL_WAIT;
                        wait_d  = WAIT_W'(CTRL_LATENCY);
                    end
                end
            end
            PIPE_CTRL_WAIT: begin
                // Fall-through instruction sits in IF/ID until resolution.
                bubble_c = 1'b1;
                wait_d   = wait_q - WAIT_W'(1);
                if (wb_ctrl_resolved) begin
                    state_d = PIPE_RUN;
                    if (wb_redirect) begin
                        pc_we_c  = 1'b1;
                        pc_sel_c = 1'b1;
                        flush_c  = 1'b1;
                    end
                end else if (wait_q <= WAIT_W'(1)) begin
                    // Last cycle of the window passed without a strobe:
                    // release as not-taken and flag it.
                    timeout_d = 1'b1;
                    state_d   = PIPE_RUN;
                end
            end
            default: state_d = PIPE_RUN;
        endcase
    end

    // Reset forces the pipeline into a safe, non-advancing, NOP-injecting state.
    assign pc_write_enable    = rst && pc_we_c;
    assign pc_sel_target      = rst && pc_sel_c;
    assign if_id_write_enable = rst && ifid_we_c;
    assign if_id_flush        = !rst || flush_c;
    assign id_ex_bubble       = !rst || bubble_c;
    assign data_stall         = rst && dstall_c;
    assign ctrl_timeout       = timeout_q;
    assign stall_cycles       = stall_q;

    assign stall_d = (id_ex_bubble && (stall_q != {STALL_CNT_W{1'b1}}))
                   ? stall_q + STALL_CNT_W'(1) : stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= PIPE_RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

endmodule

// File: doc/lapido_pipe_ctrl.md
Name: lapido_pipe_ctrl

Overview:
Hazard and sequencing controller for the 5-stage LAPI DOpaCA pipeline (IF, ID, EX, MEM, WB).
- Tracks destination registers in flight in EX, MEM and WB, and stalls ID on read-after-write hazards.
- Holds fetch while a branch or jump travels to WB, where it is resolved.
- Redirects and flushes IF/ID on a taken branch or jump.
- Drives the PC/IF-ID enables and the ID/EX bubble. Stages downstream of ID never stall.

Parameters:
CTRL_LATENCY, 3, cycles from issuing a control instruction out of ID to its expected resolution strobe in WB.
STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  in  1  pipeline clock, rising edge.
rst  in  1  asynchronous, active-low reset.
id_valid  in  1  ID holds a real instruction.
id_rs  in  5  rs field of the ID instruction.
id_rt  in  5  rt field of the ID instruction.
id_uses_rs  in  1  ID instruction reads rs.
id_uses_rt  in  1  ID instruction reads rt.
id_reg_write_enable  in  1  ID instruction writes the register file.
id_reg_dst  in  5  resolved destination register of the ID instruction.
id_is_ctrl  in  1  ID instruction is a branch, jump, jr or jal.
wb_ctrl_resolved  in  1  one-cycle strobe: a control instruction is in WB.
wb_redirect  in  1  qualified by the strobe; 1 = taken branch or jump.
pc_write_enable  out  1  PC register load enable.
pc_sel_target  out  1  PC loads the WB target address instead of PC+1.
if_id_write_enable  out  1  IF/ID register load enable.
if_id_flush  out  1  IF/ID register loads a NOP.
id_ex_bubble  out  1  ID/EX register loads a NOP (all write enables 0).
data_stall  out  1  a data hazard is active this cycle.
ctrl_timeout  out  1  sticky: the resolution strobe did not arrive in time.
stall_cycles  out  STALL_CNT_W  saturating count of cycles with id_ex_bubble=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, all tracker entries invalid, wait counter=0, ctrl_timeout=0, stall_cycles=0.
  - While rst=0, outputs are forced: pc_write_enable=0, pc_sel_target=0, if_id_write_enable=0, if_id_flush=1, id_ex_bubble=1, data_stall=0.
- Destination tracker:
  - Three entries (EX, MEM, WB), each {valid, dst}. The chain shifts every cycle.
  - EX entry receives {id_valid & id_reg_write_enable & ~id_ex_bubble & dst!=0, id_reg_dst}.
  - The register file is not write-through, so the WB entry is compared as well.
- Hazard condition:
  - hazard = id_valid & (id_uses_rs & rs!=0 & rs matches a valid entry | id_uses_rt & rt!=0 & rt matches a valid entry).
  - Register 0 never produces a hazard.
- RUN state:
  - hazard=1: data_stall=1, pc_write_enable=0, if_id_write_enable=0, id_ex_bubble=1. State is unchanged.
  - no hazard, id_valid & id_is_ctrl: the instruction issues (bubble=0, enables=1). Go to CTRL_WAIT with counter=CTRL_LATENCY.
  - otherwise: pc_write_enable=1, if_id_write_enable=1, bubble=0, flush=0.
- CTRL_WAIT state:
  - pc_write_enable=0, if_id_write_enable=0, id_ex_bubble=1. The fall-through instruction is held in IF/ID. The counter decrements each cycle.
  - wb_ctrl_resolved with wb_redirect=1: pc_write_enable=1, pc_sel_target=1, if_id_flush=1. Go to RUN.
  - wb_ctrl_resolved with wb_redirect=0: no action this cycle. Go to RUN; the held instruction issues the next cycle.
  - Counter reaches 0 with no strobe: set ctrl_timeout. Go to RUN with a non-redirect release.
- wb_ctrl_resolved in RUN is ignored (spurious strobe).
- A hazard on a control instruction stalls first; the control instruction issues only once the hazard has cleared.
- stall_cycles increments on every cycle with id_ex_bubble=1 after reset and saturates at all-ones.
- Latency: all control outputs are combinational from state, tracker and ID inputs. State and tracker update on the rising edge.

Decomposition:
- Add to lapido_defs.v:
  - state encodings: PIPE_RUN=1'b0, PIPE_CTRL_WAIT=1'b1;
  - CTRL_LATENCY default;
  - REG_ADDR_W=5.
- Sub-module lapido_dst_tracker: a 3-entry shift chain plus two match comparators. Its outputs are rs_hit and rt_hit.

Test Plan:
- Reset mid-stall: pull rst low during a data stall -> outputs are forced immediately; after release, state=RUN, tracker empty, stall_cycles=0.
- RAW hazard: an instruction writing r5 issues, next ID reads rs=5 -> data_stall=1 and bubble=1 for 3 cycles, then the consumer issues on the 4th cycle.
- r0 write: an instruction writing r0, next reads r0 -> no stall; pc_write_enable stays 1.
- Taken jump: jump issues, strobe with redirect=1 arrives 3 cycles later -> 3 bubble cycles, then pc_sel_target=1 and if_id_flush=1 for one cycle, then RUN.
- Not-taken branch: same sequence with redirect=0 -> no flush; the held PC+1 instruction issues the cycle after the strobe.
- Timeout and saturation:
  - Branch issued, no strobe -> ctrl_timeout=1 after 3 cycles and stays set.
  - With STALL_CNT_W=4, force 20 stall cycles -> stall_cycles=15.
